// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin-return sequencer; DOLLAR_COIN_EN enables the 100c coin
module change_dispenser #(
  parameter int BAL_W      = 8,
  parameter int CNT_W      = 5,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BAL_W-1:0] balance,
  input  logic             abort,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [3:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] coins_given,
  output logic [2:0]       residual,
  output logic             change_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_t;

  // Gap counter runs 0..GAP_CYCLES-1; kept at least one bit wide so GAP_CYCLES of 0 or 1 still elaborates
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [BAL_W-1:0] VAL_DOLLAR  = BAL_W'(100);
  localparam logic [BAL_W-1:0] VAL_QUARTER = BAL_W'(25);
  localparam logic [BAL_W-1:0] VAL_DIME    = BAL_W'(10);
  localparam logic [BAL_W-1:0] VAL_NICKEL  = BAL_W'(5);

`ifdef DOLLAR_COIN_EN
  localparam bit DOLLAR_EN = 1'b1;
`else
  localparam bit DOLLAR_EN = 1'b0;
`endif

  state_t           state_q;
  logic [BAL_W-1:0] remaining_q;
  logic [BAL_W-1:0] coin_val_q;
  logic [GW-1:0]    gap_q;
  logic             coin_valid_q;
  logic [3:0]       coin_sel_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] coins_given_q;
  logic [2:0]       residual_q;
  logic             change_err_q;

  logic [3:0]       sel_d;
  logic [BAL_W-1:0] val_d;

  // Largest coin that still fits in the remaining credit; all zero once below a nickel
  always_comb begin
    sel_d = 4'b0000;
    val_d = '0;
    if (DOLLAR_EN && (remaining_q >= VAL_DOLLAR)) begin
      sel_d = 4'b1000;
      val_d = VAL_DOLLAR;
    end else if (remaining_q >= VAL_QUARTER) begin
      sel_d = 4'b0100;
      val_d = VAL_QUARTER;
    end else if (remaining_q >= VAL_DIME) begin
      sel_d = 4'b0010;
      val_d = VAL_DIME;
    end else if (remaining_q >= VAL_NICKEL) begin
      sel_d = 4'b0001;
      val_d = VAL_NICKEL;
    end
  end

  // Dispense sequencer: every output is registered so the coin mechanism sees glitch-free levels
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      coin_val_q    <= '0;
      gap_q         <= '0;
      coin_valid_q  <= 1'b0;
      coin_sel_q    <= 4'b0000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      coins_given_q <= '0;
      residual_q    <= '0;
      change_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q   <= balance;
            coins_given_q <= '0;
            residual_q    <= '0;
            change_err_q  <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (abort || (sel_d == 4'b0000)) begin
            // Non-aborted exit only happens below a nickel, so the low bits are the whole leftover
            done_q       <= 1'b1;
            residual_q   <= remaining_q[2:0];
            change_err_q <= ~abort & (remaining_q != '0);
            state_q      <= S_DONE;
          end else begin
            coin_sel_q   <= sel_d;
            coin_val_q   <= val_d;
            coin_valid_q <= 1'b1;
            state_q      <= S_EJECT;
          end
        end
        S_EJECT: begin
          // Abort is deliberately not looked at here: a presented coin is never withdrawn
          if (coin_ready) begin
            remaining_q  <= remaining_q - coin_val_q;
            if (coins_given_q != '1) begin
              coins_given_q <= coins_given_q + CNT_W'(1);
            end
            coin_valid_q <= 1'b0;
            coin_sel_q   <= 4'b0000;
            gap_q        <= '0;
            state_q      <= (GAP_CYCLES > 0) ? S_GAP : S_SELECT;
          end
        end
        S_GAP: begin
          if (abort) begin
            done_q       <= 1'b1;
            residual_q   <= remaining_q[2:0];
            change_err_q <= 1'b0;
            state_q      <= S_DONE;
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_SELECT;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign coin_valid  = coin_valid_q;
  assign coin_sel    = coin_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign coins_given = coins_given_q;
  assign residual    = residual_q;
  assign change_err  = change_err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser
module tb_change_dispenser;

  localparam int BAL_W = 8;
  localparam int CNT_W = 5;
  localparam int GAP   = 2;

`ifdef DOLLAR_COIN_EN
  localparam bit TB_DOLLAR = 1'b1;
`else
  localparam bit TB_DOLLAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [BAL_W-1:0] balance;
  logic             abort;
  logic             coin_ready;
  logic             coin_valid;
  logic [3:0]       coin_sel;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] coins_given;
  logic [2:0]       residual;
  logic             change_err;

  int n_checks = 0;
  int n_errors = 0;

  change_dispenser #(
    .BAL_W(BAL_W),
    .CNT_W(CNT_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .balance(balance),
    .abort(abort),
    .coin_ready(coin_ready),
    .coin_valid(coin_valid),
    .coin_sel(coin_sel),
    .busy(busy),
    .done(done),
    .coins_given(coins_given),
    .residual(residual),
    .change_err(change_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coin_value(input int sel);
    case (sel)
      8:       return 100;
      4:       return 25;
      2:       return 10;
      1:       return 5;
      default: return 0;
    endcase
  endfunction

  // Inputs and outputs as seen by the DUT at each rising edge
  logic             e_rst_n, e_start, e_abort, e_ready, e_valid, e_done;
  logic [3:0]       e_sel;
  logic [BAL_W-1:0] e_bal;

  always @(posedge clk) begin
    e_rst_n = reset_n;
    e_start = start;
    e_abort = abort;
    e_ready = coin_ready;
    e_valid = coin_valid;
    e_done  = done;
    e_sel   = coin_sel;
    e_bal   = balance;
  end

  // Transaction model: greedy coin list, remaining credit, and cycle distances
  bit active = 1'b0;
  int exp_q[$];
  int hs_log[$];
  int rem, gave, since;
  int hold_cg = 0, hold_res = 0, hold_err = 0;
  int done_count = 0, first_lat = 0, done_lat = 0;

  initial begin : compare
    int  r, c;
    bit  aborted;
    forever begin
      @(posedge clk);
      #1;
      if (!e_rst_n) begin
        active = 1'b0;
        exp_q.delete();
        hold_cg = 0; hold_res = 0; hold_err = 0;
        check_eq("reset_outs", int'({coin_valid, coin_sel, busy, done, coins_given, residual, change_err}), 0);
      end else begin
        since++;
        if (e_done) begin
          active = 1'b0;
        end else if (!active && e_start) begin
          active = 1'b1;
          gave   = 0;
          since  = 1;
          rem    = int'(e_bal);
          exp_q.delete();
          r = rem;
          while (r >= 5) begin
            if (TB_DOLLAR && r >= 100) c = 8;
            else if (r >= 25)          c = 4;
            else if (r >= 10)          c = 2;
            else                       c = 1;
            exp_q.push_back(c);
            r -= coin_value(c);
          end
        end else if (active && e_valid && e_ready) begin
          hs_log.push_back(int'(e_sel));
          if (exp_q.size() == 0) begin
            check_eq("hs_extra_coin", int'(e_sel), 0);
          end else begin
            check_eq("hs_coin", int'(e_sel), exp_q[0]);
            rem -= coin_value(exp_q[0]);
            void'(exp_q.pop_front());
          end
          if (gave < 31) gave++;
          since = 0;
        end

        check_eq("busy", int'(busy), int'(active));
        if (!active) begin
          check_eq("idle_valid", int'(coin_valid), 0);
          check_eq("idle_done", int'(done), 0);
          check_eq("hold_coins", int'(coins_given), hold_cg);
          check_eq("hold_residual", int'(residual), hold_res);
          check_eq("hold_err", int'(change_err), hold_err);
        end else if (done) begin
          aborted  = e_abort;
          done_count++;
          done_lat = since;
          check_eq("done_valid", int'(coin_valid), 0);
          check_eq("done_coins", int'(coins_given), gave);
          check_eq("done_residual", int'(residual), rem % 8);
          check_eq("done_err", int'(change_err), int'(!aborted && rem != 0));
          if (!aborted) begin
            check_eq("done_left", exp_q.size(), 0);
            check_eq("done_lat", since, (gave == 0) ? 2 : GAP + 1);
          end
          hold_cg  = gave;
          hold_res = rem % 8;
          hold_err = int'(!aborted && rem != 0);
        end else begin
          check_eq("run_coins", int'(coins_given), gave);
          check_eq("run_residual", int'(residual), 0);
          check_eq("run_err", int'(change_err), 0);
          if (coin_valid) begin
            check_eq("sel_vs_model", int'(coin_sel), (exp_q.size() > 0) ? exp_q[0] : 0);
            if (!e_valid) begin
              check_eq("valid_lat", since, (gave == 0) ? 2 : GAP + 1);
              if (gave == 0) first_lat = since;
            end
          end else begin
            check_eq("sel_zero", int'(coin_sel), 0);
            if (e_valid && !e_ready) check_eq("valid_retracted", int'(coin_valid), 1);
          end
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", int'(done), 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!coin_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_seen", int'(coin_valid), 1);
  endtask

  task automatic launch(input int bal);
    @(negedge clk);
    hs_log.delete();
    balance = BAL_W'(bal);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_txn(input int bal);
    launch(bal);
    wait_done();
  endtask

  // Expected coin list packed one nibble per coin, first coin in the highest used nibble
  task automatic check_log(input string name, input int n, input logic [31:0] exp);
    check_eq({name, "_count"}, hs_log.size(), n);
    for (int i = 0; i < n && i < hs_log.size(); i++) begin
      check_eq(name, hs_log[i], int'((exp >> (4 * (n - 1 - i))) & 32'hF));
    end
  endtask

  initial begin : drive
    int d0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; coin_ready = 1'b0; balance = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", int'(coin_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_coins", int'(coins_given), 0);
    reset_n = 1'b1;

    // 65 cents: two quarters, a dime, a nickel
    coin_ready = 1'b1;
    d0 = done_count;
    run_txn(65);
    check_log("t65", 4, 32'h4421);
    check_eq("t65_coins", int'(coins_given), 4);
    check_eq("t65_residual", int'(residual), 0);
    check_eq("t65_err", int'(change_err), 0);
    check_eq("t65_first_lat", first_lat, 2);
    @(negedge clk);
    check_eq("t65_done_once", done_count - d0, 1);

    run_txn(140);
`ifdef DOLLAR_COIN_EN
    check_log("t140", 4, 32'h8421);
    check_eq("t140_coins", int'(coins_given), 4);
`else
    check_log("t140", 7, 32'h4444421);
    check_eq("t140_coins", int'(coins_given), 7);
`endif
    check_eq("t140_err", int'(change_err), 0);

    run_txn(7);
    check_log("t7", 1, 32'h1);
    check_eq("t7_residual", int'(residual), 2);
    check_eq("t7_err", int'(change_err), 1);

    run_txn(0);
    check_log("t0", 0, 32'h0);
    check_eq("t0_lat", done_lat, 2);
    check_eq("t0_coins", int'(coins_given), 0);

    // Mechanism stalls for five cycles on the first quarter
    coin_ready = 1'b0;
    launch(30);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check_eq("t30_hold_valid", int'(coin_valid), 1);
      check_eq("t30_hold_sel", int'(coin_sel), 4);
      check_eq("t30_hold_coins", int'(coins_given), 0);
    end
    coin_ready = 1'b1;
    wait_done();
    check_log("t30", 2, 32'h41);
    check_eq("t30_residual", int'(residual), 0);

    // Abort raised during the first eject (ignored there), honoured in the gap
    coin_ready = 1'b0;
    launch(75);
    wait_valid();
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    coin_ready = 1'b1;
    @(negedge clk);
    coin_ready = 1'b0;
    wait_done();
    check_log("t75", 1, 32'h4);
    check_eq("t75_coins", int'(coins_given), 1);
    check_eq("t75_err", int'(change_err), 0);
    check_eq("t75_residual", int'(residual), 2);
    abort = 1'b0;

    // Reset while a coin is being presented
    launch(50);
    wait_valid();
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", int'(coin_valid), 0);
    check_eq("mid_rst_sel", int'(coin_sel), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_done", int'(done), 0);
    reset_n = 1'b1;
    coin_ready = 1'b1;
    run_txn(50);
    check_log("t50", 2, 32'h44);
    check_eq("t50_coins", int'(coins_given), 2);

    // Random balances, stalls, aborts and stray starts
    for (int t = 0; t < 60; t++) begin
      bit use_abort;
      int n;
      use_abort = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      hs_log.delete();
      balance    = BAL_W'($urandom_range(0, 255));
      start      = 1'b1;
      coin_ready = ($urandom_range(0, 1) == 1);
      n = 0;
      do begin
        @(negedge clk);
        if (!done) begin
          start      = ($urandom_range(0, 7) == 0);
          coin_ready = ($urandom_range(0, 3) != 0);
          abort      = use_abort && ($urandom_range(0, 5) == 0);
        end
        n++;
      end while (!done && n < 400);
      check_eq("rnd_done_seen", int'(done), 1);
      start = 1'b0;
      abort = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
